// File: rtl/amp3_pkg.sv
// Shared definitions for the Pmod AMP3 serial transmitter: the framing mode
// and the parameter legality check applied at elaboration.
package amp3_pkg;

  // Framing mode: I2S puts the MSB one BCLK after the LRCLK edge,
  // left-justified puts it on the LRCLK edge itself.
  typedef enum logic {
    AMP3_MODE_I2S = 1'b0,
    AMP3_MODE_LJ  = 1'b1
  } amp3_mode_e;

  function automatic amp3_mode_e amp3_mode(input int lj_mode);
    return (lj_mode != 0) ? AMP3_MODE_LJ : AMP3_MODE_I2S;
  endfunction

  // Number of idle BCLK periods at the start of a slot before the MSB.
  function automatic int amp3_lead_bits(input amp3_mode_e mode);
    return (mode == AMP3_MODE_LJ) ? 0 : 1;
  endfunction

  // Even divider of at least 2, and every sample bit must fit in its slot.
  function automatic bit amp3_params_ok(input int datasize, input int slotsize,
                                        input int clkdiv, input int lj_mode);
    return (datasize >= 1) && (clkdiv >= 2) && ((clkdiv % 2) == 0) &&
           (slotsize >= datasize + amp3_lead_bits(amp3_mode(lj_mode)));
  endfunction

endpackage

// File: rtl/amp3_bclk_div.sv
// Bit-clock generator: a clk-enable style divider that produces a registered
// 50% duty BCLK plus single-cycle ticks one clk ahead of each BCLK edge.
module amp3_bclk_div #(
  parameter int CLKDIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bclk,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(CLKDIV / 2);
  localparam logic [CW-1:0] RISE_AT  = CW'(CLKDIV / 2 - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;

  // Count 0..CLKDIV-1 while running; hold at 0 otherwise so a restart
  // always begins with a full BCLK low phase.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!run) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + CW'(1);
    end
    bclk_d = run && (div_cnt_d >= DIV_HALF);
  end

  // Divider state and registered BCLK.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  // Ticks fire in the cycle before the corresponding BCLK edge so that
  // registers updated on them change together with BCLK.
  assign fall_tick = run && (div_cnt_q == DIV_LAST);
  assign rise_tick = run && (div_cnt_q == RISE_AT);
  assign bclk      = bclk_q;

endmodule

// File: rtl/amp3_i2s_tx.sv
// I2S / left-justified stereo transmitter for the Pmod AMP3 in standalone
// mode. One holding register accepts samples over valid/ready; an active
// register feeds the frame being shifted out.
module amp3_i2s_tx
  import amp3_pkg::*;
#(
  parameter int DATASIZE = 16,
  parameter int SLOTSIZE = 32,
  parameter int CLKDIV   = 16,
  parameter int LJ_MODE  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [DATASIZE-1:0] data_l,
  input  logic [DATASIZE-1:0] data_r,
  input  logic                valid,
  output logic                ready,
  output logic                SDATA,
  output logic                LRCLK,
  output logic                BCLK,
  output logic                nSHUT,
  output logic                underrun
);

  localparam int              FRAME    = 2 * SLOTSIZE;
  localparam int              PW       = $clog2(FRAME);
  localparam amp3_mode_e      MODE     = amp3_mode(LJ_MODE);
  localparam int              LEAD     = amp3_lead_bits(MODE);
  localparam logic [PW-1:0]   POS_LAST = PW'(FRAME - 1);
  localparam logic [PW-1:0]   POS_SLOT = PW'(SLOTSIZE);

  generate
    if (!amp3_params_ok(DATASIZE, SLOTSIZE, CLKDIV, LJ_MODE)) begin : g_bad_params
      $error("amp3_i2s_tx: CLKDIV must be even and >= 2, and SLOTSIZE must hold DATASIZE plus lead bit");
    end
  endgenerate

  logic                en_q, en_d;
  logic [DATASIZE-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                hold_full_q, hold_full_d;
  logic [DATASIZE-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                underrun_q, underrun_d;

  logic                run;
  logic                bclk;
  logic                fall_tick;
  logic                rise_tick;
  logic                accept;
  logic                frame_start;
  logic [PW-1:0]       slot_b;
  logic [DATASIZE-1:0] word;

  // The divider only runs once the enable has been registered, so the first
  // enabled cycle sits at div_cnt 0, and it clears as soon as enable drops.
  assign run = enable && en_q;

  amp3_bclk_div #(
    .CLKDIV (CLKDIV)
  ) u_bclk_div (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .bclk      (bclk),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  assign accept      = valid && !hold_full_q;
  assign frame_start = enable && (!en_q || (fall_tick && (pos_q == POS_LAST)));

  // Handshake, frame sequencing and the next serial bit, all advanced on
  // BCLK falling edges or on a frame start.
  always_comb begin
    en_d        = enable;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q || accept;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    pos_d       = pos_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;
    slot_b      = '0;
    word        = '0;

    if (accept) begin
      hold_l_d = data_l;
      hold_r_d = data_r;
    end

    if (!enable) begin
      // Interface idles low; the frame in flight is abandoned but the
      // holding register keeps whatever it has.
      pos_d   = '0;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
    end else if (frame_start || fall_tick) begin
      if (frame_start) begin
        pos_d       = '0;
        hold_full_d = accept;
        if (hold_full_q) begin
          act_l_d = hold_l_q;
          act_r_d = hold_r_q;
        end else begin
          act_l_d    = '0;
          act_r_d    = '0;
          underrun_d = 1'b1;
        end
      end else begin
        pos_d = pos_q + PW'(1);
      end

      lrclk_d = (pos_d >= POS_SLOT);
      slot_b  = lrclk_d ? (pos_d - POS_SLOT) : pos_d;
      word    = lrclk_d ? act_r_d : act_l_d;
      sdata_d = 1'b0;
      for (int i = 0; i < DATASIZE; i++) begin
        if (int'(slot_b) == LEAD + DATASIZE - 1 - i) begin
          sdata_d = word[i];
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      act_l_q     <= '0;
      act_r_q     <= '0;
      pos_q       <= '0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      en_q        <= en_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      pos_q       <= pos_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

  // The divider's two edge ticks can never coincide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rise_tick && fall_tick));
    end
  end

  assign ready    = !hold_full_q;
  assign SDATA    = sdata_q;
  assign LRCLK    = lrclk_q;
  assign BCLK     = bclk;
  assign nSHUT    = en_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_amp3_i2s_tx.sv
// Bench for amp3_i2s_tx: an I2S and a left-justified instance share the
// same stimulus; each frame is captured on BCLK rises and compared against
// hand-computed slot words.
module tb_amp3_i2s_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        valid;
  logic [15:0] data_l;
  logic [15:0] data_r;

  logic rdy0, sd0, lr0, bc0, ns0, ur0;
  logic rdy1, sd1, lr1, bc1, ns1, ur1;

  always #5 clk = ~clk;

  amp3_i2s_tx #(.DATASIZE(16), .SLOTSIZE(32), .CLKDIV(4), .LJ_MODE(0)) u_i2s (
    .clk(clk), .rst(rst), .enable(enable), .data_l(data_l), .data_r(data_r),
    .valid(valid), .ready(rdy0), .SDATA(sd0), .LRCLK(lr0), .BCLK(bc0),
    .nSHUT(ns0), .underrun(ur0)
  );

  amp3_i2s_tx #(.DATASIZE(16), .SLOTSIZE(32), .CLKDIV(4), .LJ_MODE(1)) u_lj (
    .clk(clk), .rst(rst), .enable(enable), .data_l(data_l), .data_r(data_r),
    .valid(valid), .ready(rdy1), .SDATA(sd1), .LRCLK(lr1), .BCLK(bc1),
    .nSHUT(ns1), .underrun(ur1)
  );

  // Samples S0..S6 and the slot words they must produce (bit 0 of the slot
  // is the MSB of the 32-bit word). I2S: sample << 15, LJ: sample << 16.
  logic [15:0] smp_l [7] = '{16'hA5C3, 16'h8001, 16'hFFFF, 16'h1234, 16'hC001, 16'h5A5A, 16'h6666};
  logic [15:0] smp_r [7] = '{16'h0F01, 16'h7FFE, 16'h0000, 16'hABCD, 16'h0280, 16'h00FF, 16'h1111};
  logic [31:0] xl_i2s [6] = '{32'h52E18000, 32'h40008000, 32'h7FFF8000, 32'h091A0000, 32'h60008000, 32'h2D2D0000};
  logic [31:0] xr_i2s [6] = '{32'h07808000, 32'h3FFF0000, 32'h00000000, 32'h55E68000, 32'h01400000, 32'h007F8000};
  logic [31:0] xl_lj  [6] = '{32'hA5C30000, 32'h80010000, 32'hFFFF0000, 32'h12340000, 32'hC0010000, 32'h5A5A0000};
  logic [31:0] xr_lj  [6] = '{32'h0F010000, 32'h7FFE0000, 32'h00000000, 32'hABCD0000, 32'h02800000, 32'h00FF0000};

  int n_chk  = 0;
  int n_pass = 0;
  int acc_cnt = 0;

  always @(posedge clk) begin
    if (!rst && valid && rdy0) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Capture one 256-clk frame; must be called so that its first negedge
  // falls in the first clk cycle of the frame.
  task automatic grab(input string name, input logic [31:0] el0, input logic [31:0] er0,
                      input logic [31:0] el1, input logic [31:0] er1,
                      input int e_und, input int e_rdy, input int e_acc);
    logic [31:0] l0, r0, l1, r1;
    int bad_clk, und0, und1, und_first, rdy_hi, a0;
    logic e_bclk, e_lr;
    l0 = '0; r0 = '0; l1 = '0; r1 = '0;
    bad_clk = 0; und0 = 0; und1 = 0; und_first = 0; rdy_hi = 0; a0 = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (c == 0) begin
        a0 = acc_cnt;
        und_first = int'(ur0);
      end
      e_bclk = ((c % 4) >= 2);
      e_lr   = (c >= 128);
      if (bc0 !== e_bclk || bc1 !== e_bclk || lr0 !== e_lr || lr1 !== e_lr ||
          ns0 !== 1'b1 || ns1 !== 1'b1 || rdy0 !== rdy1) bad_clk++;
      und0   += int'(ur0);
      und1   += int'(ur1);
      rdy_hi += int'(rdy0);
      if ((c % 4) == 2) begin
        if (c < 128) begin
          l0 = {l0[30:0], sd0};
          l1 = {l1[30:0], sd1};
        end else begin
          r0 = {r0[30:0], sd0};
          r1 = {r1[30:0], sd1};
        end
      end
    end
    $display("frame %s: i2s L=%h R=%h lj L=%h R=%h underrun=%0d ready_cycles=%0d",
             name, l0, r0, l1, r1, und0, rdy_hi);
    chk_eq({name, "_clk_lr_nshut"}, bad_clk, 0);
    chk_eq({name, "_l_i2s"}, l0, el0);
    chk_eq({name, "_r_i2s"}, r0, er0);
    chk_eq({name, "_l_lj"}, l1, el1);
    chk_eq({name, "_r_lj"}, r1, er1);
    chk_eq({name, "_underrun_first"}, und_first, e_und);
    chk_eq({name, "_underrun_i2s"}, und0, e_und);
    chk_eq({name, "_underrun_lj"}, und1, e_und);
    chk_eq({name, "_ready_cycles"}, rdy_hi, e_rdy);
    chk_eq({name, "_accepts"}, acc_cnt - a0, e_acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    rst = 1'b1; enable = 1'b0; valid = 1'b0; data_l = '0; data_r = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_outs", {bc0, lr0, sd0, ns0, ur0, rdy0, bc1, lr1, sd1, ns1, ur1, rdy1}, 32'b000001_000001);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("ready_after_rst", rdy0, 1);

    // S0 fills the hold while disabled; valid stays high from here on.
    data_l = smp_l[0]; data_r = smp_r[0]; valid = 1'b1;
    @(negedge clk);
    $display("accept S0 L=%h R=%h", smp_l[0], smp_r[0]);
    chk_eq("ready_hold_full", rdy0, 0);
    chk_eq("accept_s0", acc_cnt, 1);
    chk_eq("idle_disabled", {bc0, ns0, lr0, sd0}, 0);

    // Backpressure run: S1..S3 wait behind a full hold, one per frame.
    enable = 1'b1;
    fork
      begin
        grab("f1", xl_i2s[0], xr_i2s[0], xl_lj[0], xr_lj[0], 0, 1, 1);
        grab("f2", xl_i2s[1], xr_i2s[1], xl_lj[1], xr_lj[1], 0, 1, 1);
        grab("f3", xl_i2s[2], xr_i2s[2], xl_lj[2], xr_lj[2], 0, 1, 1);
        grab("f4", xl_i2s[3], xr_i2s[3], xl_lj[3], xr_lj[3], 0, 256, 0);
        grab("f5_underrun", 0, 0, 0, 0, 1, 256, 0);
      end
      begin
        for (int k = 1; k <= 3; k++) begin
          data_l = smp_l[k]; data_r = smp_r[k]; valid = 1'b1;
          n = 0;
          while (rdy0 !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
          end
          if (n >= 1000) chk_eq("driver_ready_timeout", n, 0);
          @(posedge clk);
          @(negedge clk);
          $display("accept S%0d L=%h R=%h", k, smp_l[k], smp_r[k]);
        end
        valid = 1'b0;
      end
    join

    // S4 arrives exactly on the frame-start edge of an empty hold.
    data_l = smp_l[4]; data_r = smp_r[4]; valid = 1'b1;
    fork
      grab("f6_same_cycle", 0, 0, 0, 0, 1, 0, 0);
      begin
        @(posedge clk);
        #1 valid = 1'b0;
      end
    join
    grab("f7", xl_i2s[4], xr_i2s[4], xl_lj[4], xr_lj[4], 0, 256, 0);

    // Buffer S5, then drop enable mid-frame for 50 clk.
    data_l = smp_l[5]; data_r = smp_r[5]; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (100) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk_eq("disable_outs", {bc0, lr0, sd0, ns0, bc1, lr1, sd1, ns1}, 0);
    chk_eq("disable_hold_kept", rdy0, 0);
    bad = 0;
    repeat (49) begin
      @(negedge clk);
      if ({bc0, lr0, sd0, ns0, bc1, lr1, sd1, ns1} !== 8'h00) bad++;
    end
    chk_eq("disable_idle_cycles", bad, 0);
    enable = 1'b1;
    grab("f9_restart", xl_i2s[5], xr_i2s[5], xl_lj[5], xr_lj[5], 0, 256, 0);

    // Buffer S6 then reset mid-frame; it must be discarded.
    data_l = smp_l[6]; data_r = smp_r[6]; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (61) @(negedge clk);
    chk_eq("pre_rst_busy", {ns0, rdy0}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("midframe_rst_outs", {bc0, lr0, sd0, ns0, ur0, rdy0, bc1, lr1, sd1, ns1, ur1, rdy1}, 32'b000001_000001);
    rst = 1'b0;
    grab("f11_after_rst", 0, 0, 0, 0, 1, 256, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
